// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its store buffer.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OFS_W      = $clog2(WORD_BYTES);
    localparam int unsigned WIDX_W     = ADDR_W - OFS_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [WIDX_W-1:0] widx;
        logic [DATA_W-1:0] data;
    } store_entry_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath-to-responder request/response bundle.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata, mem_err
    );

endinterface

// File: rtl/store_buf.sv
// Circular store FIFO with head read and a youngest-match associative search.
module store_buf
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDX_W-1:0] push_widx,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output store_entry_t      head,
    output logic [CNT_W-1:0]  count,
    input  logic [WIDX_W-1:0] search_widx,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    store_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] idx;
    logic             do_push, do_pop;

    assign do_push = push && (count_q < CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem[head_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[tail_q] <= '{valid: 1'b1, widx: push_widx, data: push_data};
                tail_q      <= tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                mem[head_q].valid <= 1'b0;
                head_q            <= head_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (mem[idx].valid && (mem[idx].widx == search_widx)) begin
                hit      = 1'b1;
                hit_data = mem[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: store buffer in front of a synchronous word RAM, with
// load forwarding, address checking and flush handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WB_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    dmem_responder_if.slave           bus,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    localparam int unsigned CNT_W  = $clog2(WB_DEPTH) + 1;
    localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE      = 2'(ST_IDLE);
    localparam logic [1:0] LOAD_WAIT = 2'(ST_LOAD_WAIT);
    localparam logic [1:0] FLUSH     = 2'(ST_FLUSH);

    logic [DATA_W-1:0] ram [DEPTH_WORDS];

    logic [1:0]        state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rvalid_q, err_q, flush_done_q;
    logic [DATA_W-1:0] rdata_q;

    logic [WIDX_W-1:0] req_widx;
    logic              addr_bad, room, accept, ld_acc, push, drain, ram_we;
    store_entry_t      head;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign req_widx = bus.mem_addr[ADDR_W-1:OFS_W];
    assign addr_bad = (bus.mem_addr[OFS_W-1:0] != '0) || (req_widx >= WIDX_W'(DEPTH_WORDS));
    assign room     = wb_count < CNT_W'(WB_DEPTH);

    always_comb begin
        bus.mem_ready = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE:      bus.mem_ready = bus.mem_we ? room : 1'b1;
                LOAD_WAIT: bus.mem_ready = bus.mem_we && room;
                default:   bus.mem_ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.mem_req && bus.mem_ready;
    assign ld_acc = accept && !bus.mem_we;
    assign push   = accept && bus.mem_we && !addr_bad;
    // The RAM port drains only in cycles where no request is accepted.
    assign drain  = reset && !accept && head.valid;
    assign ram_we = drain && (head.widx < WIDX_W'(DEPTH_WORDS));

    store_buf #(.DEPTH(WB_DEPTH)) u_store_buf (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_widx   (req_widx),
        .push_data   (bus.mem_wdata),
        .pop         (drain),
        .head        (head),
        .count       (wb_count),
        .search_widx (req_widx),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q || flush;
        case (state_q)
            IDLE: begin
                if (ld_acc) begin
                    state_d = LOAD_WAIT;
                end else if (flush_pend_d) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                end
            end
            LOAD_WAIT: state_d = IDLE;
            FLUSH:     if (wb_count == '0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            rvalid_q     <= ld_acc;
            err_q        <= accept && addr_bad;
            flush_done_q <= (state_q == FLUSH) && (wb_count == '0);
            if (ld_acc && !addr_bad) begin
                rdata_q <= hit ? hit_data : ram[req_widx[RAM_AW-1:0]];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[head.widx[RAM_AW-1:0]] <= head.data;
        end
    end

    // A response already in flight is suppressed as soon as reset lands.
    assign bus.mem_rvalid = rvalid_q && reset;
    assign bus.mem_rdata  = reset ? rdata_q : '0;
    assign bus.mem_err    = err_q && reset;
    assign flush_done     = flush_done_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus multi-cycle sequences.
module tb_dmem_responder;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       flush_done;
    logic [2:0] wb_count;

    int compared   = 0;
    int mismatched = 0;

    dmem_responder_if bus_if ();

    dmem_responder #(.DEPTH_WORDS(64), .WB_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if.slave),
        .flush      (flush),
        .flush_done (flush_done),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.mem_req   = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.mem_req   = 1'b1;
        bus_if.mem_we    = we;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
    endtask

    task automatic settle();
        bus_idle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        #1;
        while (!bus_if.mem_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.mem_ready) check({name, " ready timeout"}, 32'(bus_if.mem_ready), 32'd1);
    endtask

    // One request, then check the outputs in the cycle after acceptance.
    task automatic apply(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_rv,
                         input logic [31:0] exp_rd, input logic exp_err);
        drive(we, addr, wdata);
        wait_ready(name);
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        check({name, " rvalid"}, 32'(bus_if.mem_rvalid), 32'(exp_rv));
        check({name, " rdata"},  bus_if.mem_rdata,       exp_rd);
        check({name, " err"},    32'(bus_if.mem_err),    32'(exp_err));
    endtask

    task automatic wait_flush_done(output int k);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            @(negedge clk);
            if (flush_done) break;
        end
    endtask

    initial begin
        int k;
        int n;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0011, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0};

        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rvalid",     32'(bus_if.mem_rvalid), 32'd0);
        check("reset rdata",      bus_if.mem_rdata,       32'd0);
        check("reset err",        32'(bus_if.mem_err),    32'd0);
        check("reset flush_done", 32'(flush_done),        32'd0);
        check("reset wb_count",   32'(wb_count),          32'd0);
        check("reset ready",      32'(bus_if.mem_ready),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        settle();

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rvalid, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Store then load of the same word in the next cycle is forwarded.
        settle();
        drive(1'b1, 32'h10, 32'h1111_0000);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("fwd wb_count", 32'(wb_count),         32'd1);
        check("fwd ready",    32'(bus_if.mem_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        check("fwd rvalid", 32'(bus_if.mem_rvalid), 32'd1);
        check("fwd rdata",  bus_if.mem_rdata,       32'h1111_0000);

        // Duplicate stores: youngest wins, and RAM ends with the youngest.
        settle();
        drive(1'b1, 32'h20, 32'd1);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h20, 32'd2);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("dup wb_count", 32'(wb_count), 32'd2);
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        check("dup rvalid", 32'(bus_if.mem_rvalid), 32'd1);
        check("dup rdata",  bus_if.mem_rdata,       32'd2);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_flush_done(k);
        check("dup flush_done", 32'(flush_done), 32'd1);
        check("dup flushed count", 32'(wb_count), 32'd0);
        apply("dup ram", 1'b0, 32'h20, 32'h0, 1'b1, 32'd2, 1'b0);

        // Fill the buffer; a fifth store waits for one drain.
        settle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'hF0 + 32'(i));
            @(posedge clk);
            #1;
        end
        drive(1'b1, 32'h50, 32'hF4);
        @(negedge clk);
        check("fill wb_count", 32'(wb_count),         32'd4);
        check("fill ready",    32'(bus_if.mem_ready), 32'd0);
        n = 0;
        while (!bus_if.mem_ready && n < 10) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        check("fill wait cycles", 32'(n), 32'd1);
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        check("fill after 5th", 32'(wb_count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("fill ld%0d", i), 1'b0, 32'h40 + 32'(4 * i), 32'h0,
                  1'b1, 32'hF0 + 32'(i), 1'b0);
        end

        // Flush with three entries entering FLUSH together with the third store.
        settle();
        drive(1'b1, 32'h80, 32'hC0);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h84, 32'hC1);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h88, 32'hC2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus_idle();
        @(negedge clk);
        check("flush3 ready", 32'(bus_if.mem_ready), 32'd0);
        check("flush3 count", 32'(wb_count),         32'd3);
        wait_flush_done(k);
        check("flush3 latency", 32'(k),        32'd4);
        check("flush3 empty",   32'(wb_count), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush3 pulse width", 32'(flush_done), 32'd0);
        apply("flush3 ld", 1'b0, 32'h84, 32'h0, 1'b1, 32'hC1, 1'b0);

        // Flush with an empty buffer.
        settle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_flush_done(k);
        check("flush0 latency", 32'(k), 32'd1);

        // Reset mid-load and with a pending store.
        settle();
        apply("rst seed", 1'b1, 32'h30, 32'h30, 1'b0, 32'h0, 1'b0);
        settle();
        drive(1'b1, 32'h30, 32'hBAD0_BAD0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h30, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_idle();
        @(negedge clk);
        check("rst rvalid", 32'(bus_if.mem_rvalid), 32'd0);
        check("rst rdata",  bus_if.mem_rdata,       32'd0);
        check("rst ready",  32'(bus_if.mem_ready),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst after rvalid", 32'(bus_if.mem_rvalid), 32'd0);
        check("rst after count",  32'(wb_count),          32'd0);
        settle();
        apply("rst ram kept", 1'b0, 32'h30, 32'h0, 1'b1, 32'h30, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

endmodule
